// File: rtl/alu_result_bcd.sv
// alu_result_bcd: sequential shift-and-add-3 binary-to-BCD converter.
// It accepts one W-bit value through a valid/ready handshake, runs W
// iterations, and holds three BCD digits until downstream takes them.
module alu_result_bcd #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   hundreds,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         busy
);

  localparam int unsigned SW = 12 + W;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [SW-1:0] sr_adj, sr_shift;
  logic [3:0]    hun_q, hun_d;
  logic [3:0]    ten_q, ten_d;
  logic [3:0]    one_q, one_d;

  // One shift-and-add-3 step: correct each BCD nibble that is >= 5, then shift.
  // A corrected nibble is at most 12, so the 4-bit add never carries out.
  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sr_q[W + 4*i +: 4] >= 4'd5) begin
        sr_adj[W + 4*i +: 4] = sr_q[W + 4*i +: 4] + 4'd3;
      end
    end
    sr_shift = {sr_adj[SW-2:0], 1'b0};
  end

  // Next-state logic for the IDLE/CONV/DONE sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CONV;
          cnt_d   = '0;
          sr_d    = {12'b0, in_data};
        end
      end
      CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          hun_d   = sr_shift[W + 8 +: 4];
          ten_d   = sr_shift[W + 4 +: 4];
          one_d   = sr_shift[W     +: 4];
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      hun_q   <= '0;
      ten_q   <= '0;
      one_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign hundreds  = hun_q;
  assign tens      = ten_q;
  assign ones      = one_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Scoreboard bench for alu_result_bcd: the stimulus pushes expected digit
// triples at acceptance; a negedge monitor pops and compares on output handshakes.
module tb_alu_result_bcd;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready;
  logic         in_ready, out_valid, busy;
  logic [3:0]   hundreds, tens, ones;

  logic         rand_en = 1'b0;
  logic         or_force = 1'b1;

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           acc_cnt = 0;
  int           out_cnt = 0;
  int           last_acc_edge = 0;
  int           last_hs_edge = 0;
  logic         fresh = 1'b0;
  logic         hs_pend = 1'b0;
  logic [11:0]  sb[$];

  alu_result_bcd #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Downstream ready: forced value or random stalls, applied after the edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_en ? ($urandom_range(0, 3) != 0) : or_force;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: sees the inputs that the coming edge will sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (hs_pend) begin
        chk("in_ready_after_out_hs", int'(in_ready), 1);
        hs_pend = 1'b0;
      end
      if (out_valid && fresh) begin
        chk("latency", cyc - last_acc_edge, W);
        fresh = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        last_acc_edge = cyc + 1;
        fresh = 1'b1;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        last_hs_edge = cyc + 1;
        hs_pend = 1'b1;
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("digits", int'({hundreds, tens, ones}), int'(sb.pop_front()));
        end
      end
    end
  end

  // Present a value, hold it until accepted, record the expected digits.
  task automatic send(input logic [W-1:0] v, input logic [11:0] exp);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      sb.push_back(exp);
    end else begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int a0;
    int o0;
    logic [W-1:0] vals [6];
    logic [11:0]  exps [6];
    vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    exps = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_digits", int'({hundreds, tens, ones}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic conversion 225
    send(8'd225, 12'h225);
    wait_drain();

    // Boundaries back-to-back, acceptances 10 cycles apart
    send(vals[0], exps[0]);
    prev = last_acc_edge;
    for (int i = 1; i < 6; i++) begin
      send(vals[i], exps[i]);
      chk("accept_spacing", last_acc_edge - prev, W + 2);
      prev = last_acc_edge;
    end
    wait_drain();

    // Backpressure: 42 held, pending 7 waits
    or_force = 1'b0;
    send(8'd42, 12'h042);
    in_valid = 1'b1;
    in_data  = 8'd7;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_digits", int'({hundreds, tens, ones}), 12'h042);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    or_force = 1'b1;
    send(8'd7, 12'h007);
    chk("pending_accept_delay", last_acc_edge - last_hs_edge, 1);
    wait_drain();

    // Input ignored while busy
    a0 = acc_cnt;
    send(8'd128, 12'h128);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'd3;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    chk("accept_count_busy", acc_cnt - a0, 1);

    // Reset mid-conversion
    send(8'd199, 12'h199);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    fresh = 1'b0;
    hs_pend = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_digits", int'({hundreds, tens, ones}), 0);
    @(posedge clk);
    #1;
    send(8'd57, 12'h057);
    wait_drain();

    // Exhaustive sweep with random stalls
    o0 = out_cnt;
    rand_en = 1'b1;
    for (int v = 0; v < 256; v++) begin
      send(W'(v), {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
    end
    wait_drain();
    rand_en = 1'b0;
    chk("sweep_outputs", out_cnt - o0, 256);
    chk("sb_empty", sb.size(), 0);
    chk("total_transfers", out_cnt, acc_cnt - 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
